// File: rtl/tqvp_pdm_tx.sv
// TinyQV PDM transmitter: a small PCM sample FIFO feeding a first-order sigma-delta modulator
// that drives a PDM clock/data pair on the output PMOD.
module tqvp_pdm_tx #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int unsigned Aw = $clog2(FIFO_DEPTH);
    localparam int unsigned Cw = Aw + 1;

    localparam logic [5:0] AddrCtrl   = 6'h00;
    localparam logic [5:0] AddrClkdiv = 6'h04;
    localparam logic [5:0] AddrOsr    = 6'h08;
    localparam logic [5:0] AddrData   = 6'h0C;
    localparam logic [5:0] AddrStatus = 6'h10;

    logic [7:0]    ctrl_q, ctrl_d;
    logic [7:0]    clkdiv_q, clkdiv_d;
    logic [15:0]   osr_q, osr_d;
    logic [15:0]   fifo_q [FIFO_DEPTH];
    logic [Aw-1:0] wr_ptr_q, rd_ptr_q;
    logic [Cw-1:0] count_q, count_d;
    logic [15:0]   cur_sample_q, cur_sample_d;
    logic [15:0]   acc_q, acc_d;
    logic [7:0]    div_q, div_d;
    logic [15:0]   bitcnt_q, bitcnt_d;
    logic          pdm_clk_q, pdm_clk_d;
    logic          pdm_dat_q, pdm_dat_d;
    logic          unf_q, unf_d;
    logic          ovf_q, ovf_d;
    logic          irq_q, irq_d;

    logic          en, irqen;
    logic [2:0]    thresh;
    logic          wr_any, wr_wide, push, push_ok;
    logic          fifo_empty, fifo_full;
    logic          div_wrap, bit_tick, boundary, pop;
    logic [15:0]   mod_sample, mod_u;
    logic [16:0]   mod_sum;
    logic [3:0]    level;

    assign en     = ctrl_q[0];
    assign irqen  = ctrl_q[1];
    assign thresh = ctrl_q[4:2];

    assign wr_any     = data_write_n != 2'b11;
    assign wr_wide    = wr_any && (data_write_n != 2'b00);
    assign push       = wr_wide && (address == AddrData);
    assign fifo_empty = count_q == '0;
    assign fifo_full  = count_q == Cw'(FIFO_DEPTH);
    assign push_ok    = push && !fifo_full;

    // A bit tick is the divider wrap on which pdm_clk falls.
    assign div_wrap = en && (div_q == clkdiv_q);
    assign bit_tick = div_wrap && pdm_clk_q;
    assign boundary = bit_tick && (bitcnt_q == '0);
    assign pop      = boundary && !fifo_empty;

    // The sample popped at a boundary is modulated on that same tick.
    assign mod_sample = pop ? fifo_q[rd_ptr_q] : cur_sample_q;
    assign mod_u      = mod_sample ^ 16'h8000;
    assign mod_sum    = {1'b0, acc_q} + {1'b0, mod_u};
    assign level      = 4'(count_q);

    always_comb begin
        ctrl_d   = ctrl_q;
        clkdiv_d = clkdiv_q;
        osr_d    = osr_q;
        unf_d    = unf_q;
        ovf_d    = ovf_q;
        if (wr_any) begin
            case (address)
                AddrCtrl:   ctrl_d = data_in[7:0];
                AddrClkdiv: clkdiv_d = data_in[7:0];
                AddrOsr: begin
                    if (wr_wide) osr_d = data_in[15:0];
                    else         osr_d[7:0] = data_in[7:0];
                end
                AddrStatus: begin
                    if (data_in[4]) unf_d = 1'b0;
                    if (data_in[5]) ovf_d = 1'b0;
                end
                default: ;
            endcase
        end
        if (push && fifo_full)     ovf_d = 1'b1;
        if (boundary && fifo_empty) unf_d = 1'b1;
    end

    always_comb begin
        div_d        = div_q;
        bitcnt_d     = bitcnt_q;
        pdm_clk_d    = pdm_clk_q;
        pdm_dat_d    = pdm_dat_q;
        acc_d        = acc_q;
        cur_sample_d = cur_sample_q;
        if (!en) begin
            div_d     = '0;
            bitcnt_d  = '0;
            pdm_clk_d = 1'b0;
            pdm_dat_d = 1'b0;
            acc_d     = '0;
        end else begin
            if (div_wrap) begin
                div_d     = '0;
                pdm_clk_d = ~pdm_clk_q;
            end else begin
                div_d = div_q + 8'd1;
            end
            if (bit_tick) begin
                bitcnt_d     = (bitcnt_q == osr_q) ? '0 : bitcnt_q + 16'd1;
                acc_d        = mod_sum[15:0];
                pdm_dat_d    = mod_sum[16];
                cur_sample_d = mod_sample;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + Cw'(1);
        else if (pop && !push_ok) count_d = count_q - Cw'(1);
    end

    assign irq_d = en && irqen && (level <= {1'b0, thresh});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q       <= '0;
            clkdiv_q     <= '0;
            osr_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cur_sample_q <= '0;
            acc_q        <= '0;
            div_q        <= '0;
            bitcnt_q     <= '0;
            pdm_clk_q    <= 1'b0;
            pdm_dat_q    <= 1'b0;
            unf_q        <= 1'b0;
            ovf_q        <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            clkdiv_q     <= clkdiv_d;
            osr_q        <= osr_d;
            count_q      <= count_d;
            cur_sample_q <= cur_sample_d;
            acc_q        <= acc_d;
            div_q        <= div_d;
            bitcnt_q     <= bitcnt_d;
            pdm_clk_q    <= pdm_clk_d;
            pdm_dat_q    <= pdm_dat_d;
            unf_q        <= unf_d;
            ovf_q        <= ovf_d;
            irq_q        <= irq_d;
            if (push_ok) begin
                fifo_q[wr_ptr_q] <= data_in[15:0];
                wr_ptr_q         <= wr_ptr_q + Aw'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + Aw'(1);
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            AddrCtrl:   data_out = {24'h0, ctrl_q};
            AddrClkdiv: data_out = {24'h0, clkdiv_q};
            AddrOsr:    data_out = {16'h0, osr_q};
            AddrData:   data_out = {16'h0, cur_sample_q};
            AddrStatus: data_out = {26'h0, ovf_q, unf_q, level};
            default:    ;
        endcase
    end

    assign uo_out         = {5'b0, en & pdm_dat_q, en & pdm_clk_q, 1'b0};
    assign data_ready     = 1'b1;
    assign user_interrupt = irq_q;

    logic unused;
    assign unused = &{1'b0, ui_in, data_read_n, data_in[31:16]};

endmodule

// File: tb/tb_tqvp_pdm_tx.sv
// Self-checking bench for tqvp_pdm_tx: register vector table, PDM bit scoreboard and
// hand-written FIFO, interrupt and disable sequences.
module tb_tqvp_pdm_tx;

    localparam logic [5:0] A_CTRL   = 6'h00;
    localparam logic [5:0] A_CLKDIV = 6'h04;
    localparam logic [5:0] A_OSR    = 6'h08;
    localparam logic [5:0] A_DATA   = 6'h0C;
    localparam logic [5:0] A_STATUS = 6'h10;

    logic        clk;
    logic        rst_n;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    tqvp_pdm_tx #(.FIFO_DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ui_in          (ui_in),
        .uo_out         (uo_out),
        .address        (address),
        .data_in        (data_in),
        .data_write_n   (data_write_n),
        .data_read_n    (data_read_n),
        .data_out       (data_out),
        .data_ready     (data_ready),
        .user_interrupt (user_interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_pass = 0;
    int          n_total = 0;
    logic        exp_q[$];
    logic [15:0] samp_q[$];
    logic [15:0] m_acc;
    logic        mon_armed;
    logic        prev_clk;
    logic        exp_bit;
    int          bit_idx;

    typedef struct {
        logic [5:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  wmode;
        logic [5:0]  raddr;
        logic [31:0] rexp;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [31:0] d, input logic [1:0] w);
        @(negedge clk);
        address      = a;
        data_in      = d;
        data_write_n = w;
        @(negedge clk);
        data_write_n = 2'b11;
    endtask

    task automatic read_chk(input logic [5:0] a, input logic [31:0] exp, input string name);
        address = a;
        #1;
        check(name, data_out, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference first-order sigma-delta: one bit per call step, carry of acc + offset-binary.
    task automatic model_bits(input logic [15:0] s, input int n);
        logic [16:0] sum;
        for (int i = 0; i < n; i++) begin
            sum   = {1'b0, m_acc} + {1'b0, s ^ 16'h8000};
            m_acc = sum[15:0];
            exp_q.push_back(sum[16]);
        end
    endtask

    task automatic wait_q(input int limit, input int budget, input string name);
        int n = 0;
        while (exp_q.size() > limit && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), limit);
        if (exp_q.size() > limit) exp_q.delete();
    endtask

    task automatic poll_level(input logic [3:0] target, input int budget, input string name);
        int n = 0;
        address = A_STATUS;
        #1;
        while (data_out[3:0] != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, data_out[3:0], target);
    endtask

    // Bit monitor: compares pdm_dat at pdm_clk rising edges that follow a falling edge.
    initial begin
        prev_clk  = 1'b0;
        mon_armed = 1'b0;
        bit_idx   = 0;
        forever begin
            @(negedge clk);
            if (prev_clk && !uo_out[1]) mon_armed = 1'b1;
            if (!prev_clk && uo_out[1] && mon_armed && exp_q.size() > 0) begin
                exp_bit = exp_q.pop_front();
                check($sformatf("pdm_bit%0d", bit_idx), 32'(uo_out[2]), 32'(exp_bit));
                bit_idx++;
            end
            prev_clk = uo_out[1];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, required completion before 2 ms");
        $fatal(1, "bench timed out");
    end

    initial begin
        vecs[0]  = '{A_CTRL,   32'h0000_001C, 2'b10, A_CTRL,   32'h1C};
        vecs[1]  = '{A_CTRL,   32'hFFFF_FF00, 2'b00, A_CTRL,   32'h00};
        vecs[2]  = '{A_CLKDIV, 32'h0000_00AB, 2'b00, A_CLKDIV, 32'hAB};
        vecs[3]  = '{A_CLKDIV, 32'h1234_5603, 2'b01, A_CLKDIV, 32'h03};
        vecs[4]  = '{A_OSR,    32'hDEAD_1234, 2'b10, A_OSR,    32'h1234};
        vecs[5]  = '{A_OSR,    32'h0000_00FF, 2'b00, A_OSR,    32'h12FF};
        vecs[6]  = '{A_OSR,    32'h0000_ABCD, 2'b01, A_OSR,    32'hABCD};
        vecs[7]  = '{A_DATA,   32'h0000_1111, 2'b00, A_STATUS, 32'h0};
        vecs[8]  = '{6'h14,    32'hFFFF_FFFF, 2'b10, 6'h14,    32'h0};
        vecs[9]  = '{A_DATA,   32'h0000_BEEF, 2'b01, A_STATUS, 32'h1};
        vecs[10] = '{A_STATUS, 32'h0000_0030, 2'b10, A_STATUS, 32'h1};
        vecs[11] = '{A_CTRL,   32'h0,         2'b11, 6'h3C,    32'h0};
        vecs[12] = '{A_CTRL,   32'h0,         2'b11, A_DATA,   32'h0};

        rst_n        = 1'b0;
        ui_in        = '0;
        address      = '0;
        data_in      = '0;
        data_write_n = 2'b11;
        data_read_n  = 2'b11;
        m_acc        = '0;

        // Reset held with random bus traffic.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("rst_uo%0d", i), 32'(uo_out), 0);
            check($sformatf("rst_irq%0d", i), 32'(user_interrupt), 0);
            address      = 6'($urandom_range(0, 5) * 4);
            data_in      = $urandom;
            data_write_n = 2'($urandom);
            data_read_n  = 2'($urandom);
            ui_in        = 8'($urandom);
        end
        @(negedge clk);
        data_write_n = 2'b11;
        @(negedge clk);
        for (int i = 0; i < 5; i++) read_chk(6'(i * 4), 32'h0, $sformatf("rst_read%0d", i));
        check("data_ready", 32'(data_ready), 1);
        rst_n = 1'b1;

        // Register access table.
        for (int i = 0; i < 13; i++) begin
            bus_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wmode);
            read_chk(vecs[i].raddr, vecs[i].rexp, $sformatf("vec%0d", i));
        end
        do_reset();

        // Mid-scale: alternating stream, pdm_clk = clk/2.
        bus_write(A_CLKDIV, 32'h0, 2'b10);
        bus_write(A_OSR, 32'h7, 2'b01);
        bus_write(A_DATA, 32'h0, 2'b01);
        read_chk(A_STATUS, 32'h1, "ms_level1");
        for (int i = 0; i < 16; i++) exp_q.push_back(i[0]);
        mon_armed = 1'b0;
        bus_write(A_CTRL, 32'h1, 2'b10);
        read_chk(A_STATUS, 32'h1, "ms_lvl_p0");
        check("ms_clk_p0", 32'(uo_out[1]), 0);
        @(negedge clk);
        check("ms_lvl_p1", 32'(data_out[3:0]), 1);
        check("ms_clk_p1", 32'(uo_out[1]), 1);
        @(negedge clk);
        check("ms_lvl_p2", 32'(data_out[3:0]), 0);
        check("ms_clk_p2", 32'(uo_out[1]), 0);
        wait_q(0, 200, "ms_bits_done");
        read_chk(A_STATUS, 32'h10, "ms_unf");
        bus_write(A_CTRL, 32'h0, 2'b10);
        check("ms_off_uo", 32'(uo_out), 0);
        bus_write(A_STATUS, 32'h10, 2'b10);
        read_chk(A_STATUS, 32'h0, "ms_unf_clr");

        // Extremes: full-scale positive then negative, held on underrun.
        m_acc = '0;
        bus_write(A_CLKDIV, 32'h1, 2'b00);
        bus_write(A_OSR, 32'hF, 2'b01);
        bus_write(A_DATA, 32'h7FFF, 2'b01);
        bus_write(A_DATA, 32'h8000, 2'b10);
        model_bits(16'h7FFF, 16);
        model_bits(16'h8000, 32);
        mon_armed = 1'b0;
        bus_write(A_CTRL, 32'h1, 2'b10);
        wait_q(16, 400, "ext_first32");
        read_chk(A_STATUS, 32'h0, "ext_unf_before");
        wait_q(0, 400, "ext_all");
        address = A_STATUS;
        #1;
        check("ext_unf_after", 32'(data_out[4]), 1);
        read_chk(A_DATA, 32'h8000, "ext_held");
        do_reset();

        // FIFO overflow and ordering.
        for (int i = 0; i < 5; i++) begin
            bus_write(A_DATA, 32'h1001 * (i + 1), 2'b01);
            if (i < 4) samp_q.push_back(16'(32'h1001 * (i + 1)));
            if (i == 3) read_chk(A_STATUS, 32'h04, "fifo_full_noovf");
        end
        read_chk(A_STATUS, 32'h24, "fifo_ovf");
        bus_write(A_STATUS, 32'h20, 2'b10);
        read_chk(A_STATUS, 32'h04, "fifo_ovf_clr");
        bus_write(A_CTRL, 32'h1, 2'b10);
        begin
            logic [15:0] last_cur;
            last_cur = '0;
            address  = A_DATA;
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (data_out[15:0] != last_cur) begin
                    last_cur = data_out[15:0];
                    if (samp_q.size() > 0)
                        check($sformatf("fifo_pop%0d", n), 32'(last_cur), 32'(samp_q.pop_front()));
                end
            end
        end
        check("fifo_all_popped", samp_q.size(), 0);
        read_chk(A_DATA, 32'h4004, "fifo_fifth_dropped");
        read_chk(A_STATUS, 32'h10, "fifo_drained_unf");
        do_reset();

        // Interrupt threshold.
        bus_write(A_CLKDIV, 32'h3, 2'b00);
        for (int i = 0; i < 3; i++) bus_write(A_DATA, 32'h100 * (i + 1), 2'b01);
        check("irq_disabled", 32'(user_interrupt), 0);
        bus_write(A_CTRL, 32'h07, 2'b10);
        check("irq_lvl3", 32'(user_interrupt), 0);
        poll_level(4'd1, 100, "irq_lvl1");
        check("irq_pre", 32'(user_interrupt), 0);
        @(negedge clk);
        check("irq_assert", 32'(user_interrupt), 1);
        bus_write(A_DATA, 32'h0400, 2'b10);
        read_chk(A_STATUS, 32'h02, "irq_lvl2");
        check("irq_hold", 32'(user_interrupt), 1);
        @(negedge clk);
        check("irq_deassert", 32'(user_interrupt), 0);
        do_reset();

        // Disable mid-sample, then re-enable.
        bus_write(A_OSR, 32'h3, 2'b01);
        bus_write(A_DATA, 32'h4000, 2'b01);
        bus_write(A_DATA, 32'h1234, 2'b01);
        bus_write(A_DATA, 32'h0F00, 2'b01);
        bus_write(A_CTRL, 32'h1, 2'b10);
        poll_level(4'd2, 20, "dis_first");
        bus_write(A_CTRL, 32'h0, 2'b10);
        check("dis_uo_now", 32'(uo_out[2:1]), 0);
        read_chk(A_STATUS, 32'h02, "dis_fifo_kept");
        read_chk(A_DATA, 32'h4000, "dis_cur_kept");
        repeat (5) @(negedge clk);
        check("dis_uo_later", 32'(uo_out), 0);
        m_acc = '0;
        model_bits(16'h1234, 4);
        model_bits(16'h0F00, 4);
        mon_armed = 1'b0;
        bus_write(A_CTRL, 32'h1, 2'b10);
        poll_level(4'd1, 20, "dis_reen_pop");
        read_chk(A_DATA, 32'h1234, "dis_reen_cur");
        wait_q(0, 200, "dis_bits_done");
        address = A_STATUS;
        #1;
        check("dis_final_lvl", 32'(data_out[3:0]), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
